hub75_rx_capture: RTL and testbench

- Receive-side counterpart of the HUB75 panel driver.
- Oversamples the panel bus (LP_CLK, LATCH, NOE, ROW, RGB0, RGB1) on the system clock and reassembles each shifted line into per-column pixel words.
- On every latch, emits the committed line as a valid/ready pixel stream tagged with row, column and bit-plane, plus the measured NOE on-time.
- Used for loopback self-test of the driver and as the bench's golden monitor.

---
 rtl/hub75_rx_capture.sv | 198 +++++++++++++++++++
 tb/tb_hub75_rx_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hub75_rx_capture.sv
// rtl/hub75_rx_capture.sv - HUB75 bus oversampling receiver: line capture, bank swap, pixel stream out
module hub75_rx_capture #(
  parameter int COLS      = 64,
  parameter int ROW_W     = 5,
  parameter int PLANE_W   = 2,
  parameter int LATCH_POL = 1,
  parameter int ONT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lp_clk,
  input  logic                     latch,
  input  logic                     noe,
  input  logic [ROW_W-1:0]         row,
  input  logic [2:0]               rgb0,
  input  logic [2:0]               rgb1,
  output logic                     px_valid,
  input  logic                     px_ready,
  output logic [ROW_W-1:0]         px_row,
  output logic [$clog2(COLS)-1:0]  px_col,
  output logic [PLANE_W-1:0]       px_plane,
  output logic [5:0]               px_rgb,
  output logic                     px_sol,
  output logic [ONT_W-1:0]         line_on_time,
  output logic                     err_short,
  output logic                     err_overrun
);

  localparam int COL_W = $clog2(COLS);
  localparam logic [COL_W:0]   COLS_V   = (COL_W+1)'(COLS);
  localparam logic [COL_W:0]   CNT_ONE  = (COL_W+1)'(1);
  localparam logic [COL_W-1:0] LAST_COL = (COL_W)'(COLS-1);
  localparam logic [COL_W-1:0] COL_ONE  = (COL_W)'(1);
  localparam logic [PLANE_W-1:0] PL_ONE = (PLANE_W)'(1);
  localparam logic [ONT_W-1:0] ONT_ONE  = (ONT_W)'(1);
  localparam logic [ONT_W-1:0] ONT_MAX  = '1;
  localparam logic LA_ON   = (LATCH_POL != 0);
  localparam logic LA_IDLE = (LATCH_POL == 0);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t state, state_next;

  // synchroniser stages; third stage on lp_clk/latch is only for edge detection
  logic             lp_s1, lp_s2, lp_s3;
  logic             la_s1, la_s2, la_s3;
  logic             noe_s1, noe_s2;
  logic [ROW_W-1:0] row_s1, row_s2;
  logic [5:0]       rgb_s1, rgb_s2;

  logic lp_rise, lat_edge;

  // line storage: two banks of COLS pixel words, addressed {bank, column}
  logic [5:0]       mem [2*COLS];
  logic             fill_sel;
  logic [COL_W:0]   col_cnt, col_after;
  logic [ONT_W-1:0] ont_cnt;
  logic [PLANE_W-1:0] plane, plane_new;
  logic [ROW_W-1:0] last_row;

  // tag of the line currently being drained
  logic [ROW_W-1:0]   tag_row;
  logic [PLANE_W-1:0] tag_plane;
  logic [ONT_W-1:0]   tag_ont;

  logic shift_en, shift_drop, commit, lat_short, lat_overrun;
  logic accept, last_accept;

  assign lp_rise     = lp_s2 & ~lp_s3;
  assign lat_edge    = (la_s2 == LA_ON) && (la_s3 != LA_ON);
  assign accept      = px_valid && px_ready;
  assign last_accept = accept && (px_col == LAST_COL);
  assign plane_new   = (row_s2 == last_row) ? plane + PL_ONE : '0;

  // two-flop synchronisers; idle levels on reset so no false edge or on-time appears
  always_ff @(posedge clk) begin
    if (rst) begin
      lp_s1  <= 1'b0;    lp_s2  <= 1'b0;    lp_s3 <= 1'b0;
      la_s1  <= LA_IDLE; la_s2  <= LA_IDLE; la_s3 <= LA_IDLE;
      noe_s1 <= 1'b1;    noe_s2 <= 1'b1;
      row_s1 <= '0;      row_s2 <= '0;
      rgb_s1 <= '0;      rgb_s2 <= '0;
    end else begin
      lp_s1  <= lp_clk;  lp_s2  <= lp_s1;   lp_s3 <= lp_s2;
      la_s1  <= latch;   la_s2  <= la_s1;   la_s3 <= la_s2;
      noe_s1 <= noe;     noe_s2 <= noe_s1;
      row_s1 <= row;     row_s2 <= row_s1;
      rgb_s1 <= {rgb0, rgb1};
      rgb_s2 <= rgb_s1;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next state and per-cycle events; the shift is resolved before the latch looks at col_cnt
  always_comb begin
    state_next  = state;
    shift_en    = 1'b0;
    shift_drop  = 1'b0;
    col_after   = col_cnt;
    commit      = 1'b0;
    lat_short   = 1'b0;
    lat_overrun = 1'b0;
    if (lp_rise) begin
      if (col_cnt < COLS_V) begin
        shift_en  = 1'b1;
        col_after = col_cnt + CNT_ONE;
      end else begin
        shift_drop = 1'b1;
      end
    end
    case (state)
      IDLE: begin
        if (lp_rise) state_next = SHIFT;
      end
      SHIFT: begin
        if (lat_edge) begin
          if (col_after == COLS_V) begin
            commit     = 1'b1;
            state_next = DRAIN;
          end else begin
            lat_short = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (last_accept) state_next = SHIFT;
        if (lat_edge) begin
          if (col_after == COLS_V) lat_overrun = 1'b1;
          else                     lat_short   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // pixel write into the fill bank
  always_ff @(posedge clk) begin
    if (shift_en && !rst) mem[{fill_sel, col_cnt[COL_W-1:0]}] <= rgb_s2;
  end

  // column counter, on-time counter, bank swap, plane tracking, drain pointer and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt     <= '0;
      ont_cnt     <= '0;
      fill_sel    <= 1'b0;
      plane       <= '0;
      last_row    <= '1;
      tag_row     <= '0;
      tag_plane   <= '0;
      tag_ont     <= '0;
      px_valid    <= 1'b0;
      px_col      <= '0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (lat_edge && state != IDLE) col_cnt <= '0;
      else                           col_cnt <= col_after;

      if (lat_edge)                          ont_cnt <= '0;
      else if (!noe_s2 && ont_cnt != ONT_MAX) ont_cnt <= ont_cnt + ONT_ONE;

      if (commit) begin
        fill_sel  <= ~fill_sel;
        tag_row   <= row_s2;
        tag_plane <= plane_new;
        tag_ont   <= ont_cnt;
        plane     <= plane_new;
        last_row  <= row_s2;
        px_valid  <= 1'b1;
        px_col    <= '0;
      end else if (accept) begin
        if (last_accept) begin
          px_valid <= 1'b0;
          px_col   <= '0;
        end else begin
          px_col <= px_col + COL_ONE;
        end
      end

      err_short <= lat_short;
      if (shift_drop || lat_overrun) err_overrun <= 1'b1;
    end
  end

  // drain bank is always the one not being filled
  assign px_rgb       = px_valid ? mem[{~fill_sel, px_col}] : 6'd0;
  assign px_sol       = px_valid && (px_col == '0);
  assign line_on_time = px_sol ? tag_ont : '0;
  assign px_row       = tag_row;
  assign px_plane     = tag_plane;

endmodule

// File: tb/tb_hub75_rx_capture.sv
// tb/tb_hub75_rx_capture.sv - directed bench for hub75_rx_capture
module tb_hub75_rx_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lp_clk = 1'b0;
  logic       latch = 1'b0;
  logic       noe = 1'b1;
  logic [4:0] row = '0;
  logic [2:0] rgb0 = '0;
  logic [2:0] rgb1 = '0;
  logic       px_ready = 1'b0;
  logic       px_valid, px_sol, err_short, err_overrun;
  logic [4:0] px_row;
  logic [5:0] px_col;
  logic [1:0] px_plane;
  logic [5:0] px_rgb;
  logic [15:0] line_on_time;

  int vectors = 0;
  int miscompares = 0;

  hub75_rx_capture dut (
    .clk(clk), .rst(rst), .lp_clk(lp_clk), .latch(latch), .noe(noe), .row(row),
    .rgb0(rgb0), .rgb1(rgb1), .px_valid(px_valid), .px_ready(px_ready),
    .px_row(px_row), .px_col(px_col), .px_plane(px_plane), .px_rgb(px_rgb),
    .px_sol(px_sol), .line_on_time(line_on_time), .err_short(err_short),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] pat(input int c, input logic [2:0] k);
    logic [2:0] cc;
    cc = c[2:0];
    return {cc ^ k, ~cc};
  endfunction

  task automatic shift_pulses(input int n, input logic [4:0] r, input logic [2:0] k, input int noe_low);
    int cyc = 0;
    logic [5:0] p;
    row = r;
    for (int i = 0; i < n; i++) begin
      p = pat(i, k);
      {rgb0, rgb1} = p;
      for (int h = 0; h < 6; h++) begin
        lp_clk = (h >= 3);
        noe = (cyc < noe_low) ? 1'b0 : 1'b1;
        step();
        cyc++;
      end
    end
    lp_clk = 1'b0;
    noe = 1'b1;
    step();
  endtask

  task automatic do_latch();
    latch = 1'b1;
    step(2);
    latch = 1'b0;
    step();
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (!px_valid && t < 2000) begin
      step();
      t++;
    end
    if (!px_valid) chk({tag, "_timeout"}, 32'(px_valid), 32'd1);
  endtask

  task automatic collect(input int n, input logic [4:0] r, input logic [1:0] pl,
                         input logic [15:0] ont, input logic [2:0] k, input string tag);
    wait_valid(tag);
    px_ready = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (!px_valid) wait_valid(tag);
      chk($sformatf("%s_col%0d", tag, c), 32'(px_col), 32'(c));
      chk($sformatf("%s_rgb%0d", tag, c), 32'(px_rgb), 32'(pat(c, k)));
      chk($sformatf("%s_sol%0d", tag, c), 32'(px_sol), 32'(c == 0));
      if (c == 0) begin
        chk({tag, "_row"}, 32'(px_row), 32'(r));
        chk({tag, "_plane"}, 32'(px_plane), 32'(pl));
        chk({tag, "_ontime"}, 32'(line_on_time), 32'(ont));
      end
      step();
    end
    px_ready = 1'b0;
    if (n == 64) chk({tag, "_valid_drop"}, 32'(px_valid), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(px_valid), 32'd0);
    chk({tag, "_sol"}, 32'(px_sol), 32'd0);
    chk({tag, "_col"}, 32'(px_col), 32'd0);
    chk({tag, "_rgb"}, 32'(px_rgb), 32'd0);
    chk({tag, "_row"}, 32'(px_row), 32'd0);
    chk({tag, "_plane"}, 32'(px_plane), 32'd0);
    chk({tag, "_ontime"}, 32'(line_on_time), 32'd0);
    chk({tag, "_short"}, 32'(err_short), 32'd0);
    chk({tag, "_overrun"}, 32'(err_overrun), 32'd0);
  endtask

  // directed sequence
  initial begin
    int sc;
    int vs;

    step(3);
    chk_zero("reset");
    rst = 1'b0;
    step(2);

    // full line on row 3, then repeats walking the plane counter
    shift_pulses(64, 5'd3, 3'd0, 0); do_latch(); collect(64, 5'd3, 2'd0, 16'd0, 3'd0, "l1");
    shift_pulses(64, 5'd3, 3'd1, 0); do_latch(); collect(64, 5'd3, 2'd1, 16'd0, 3'd1, "l2");
    shift_pulses(64, 5'd3, 3'd2, 0); do_latch(); collect(64, 5'd3, 2'd2, 16'd0, 3'd2, "l3");
    shift_pulses(64, 5'd3, 3'd3, 0); do_latch(); collect(64, 5'd3, 2'd3, 16'd0, 3'd3, "l4");
    shift_pulses(64, 5'd3, 3'd4, 0); do_latch(); collect(64, 5'd3, 2'd0, 16'd0, 3'd4, "l5");
    // row change resets plane; noe low exactly 200 clk during this line
    shift_pulses(64, 5'd4, 3'd5, 200); do_latch(); collect(64, 5'd4, 2'd0, 16'd200, 3'd5, "l6");

    // short line: 40 pulses then latch
    shift_pulses(40, 5'd4, 3'd6, 0);
    sc = 0; vs = 0;
    latch = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) latch = 1'b0;
      step();
      sc += int'(err_short);
      vs |= int'(px_valid);
    end
    chk("short_pulse_count", 32'(sc), 32'd1);
    chk("short_no_valid", 32'(vs), 32'd0);
    chk("short_no_overrun", 32'(err_overrun), 32'd0);
    shift_pulses(64, 5'd4, 3'd7, 0); do_latch(); collect(64, 5'd4, 2'd1, 16'd0, 3'd7, "l7");

    // backpressure: line A stalls while line B shifts and latches
    shift_pulses(64, 5'd7, 3'd1, 0); do_latch();
    step(2);
    chk("stall_valid", 32'(px_valid), 32'd1);
    chk("stall_col0", 32'(px_col), 32'd0);
    chk("stall_rgb0", 32'(px_rgb), 32'(pat(0, 3'd1)));
    shift_pulses(64, 5'd7, 3'd2, 0);
    chk("pre_overrun", 32'(err_overrun), 32'd0);
    do_latch();
    step(110);
    chk("overrun_set", 32'(err_overrun), 32'd1);
    chk("stall_hold_valid", 32'(px_valid), 32'd1);
    chk("stall_hold_col", 32'(px_col), 32'd0);
    chk("stall_hold_rgb", 32'(px_rgb), 32'(pat(0, 3'd1)));
    collect(64, 5'd7, 2'd0, 16'd0, 3'd1, "la");
    vs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      vs |= int'(px_valid);
    end
    chk("lb_dropped", 32'(vs), 32'd0);

    // on-time saturation
    noe = 1'b0;
    step(70000);
    noe = 1'b1;
    shift_pulses(64, 5'd8, 3'd3, 0); do_latch(); collect(64, 5'd8, 2'd0, 16'hffff, 3'd3, "sat");
    chk("overrun_sticky", 32'(err_overrun), 32'd1);

    // reset mid-line
    shift_pulses(30, 5'd9, 3'd4, 0);
    rst = 1'b1;
    step();
    chk_zero("rst_shift");
    rst = 1'b0;
    step(2);

    // reset mid-drain at column 10
    shift_pulses(64, 5'd9, 3'd4, 0); do_latch(); collect(10, 5'd9, 2'd0, 16'd0, 3'd4, "pre_rst");
    chk("drain_at_col10", 32'(px_col), 32'd10);
    rst = 1'b1;
    step();
    chk_zero("rst_drain");
    rst = 1'b0;
    step(2);

    // same row after reset must start at plane 0
    shift_pulses(64, 5'd9, 3'd5, 0); do_latch(); collect(64, 5'd9, 2'd0, 16'd0, 3'd5, "post_rst");
    chk("post_rst_short", 32'(err_short), 32'd0);
    chk("post_rst_overrun", 32'(err_overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
